// File: rtl/hash_table_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hash_table_pkg
//  Description : Shared widths, command/status codes and the slot-state type
//                for the probing hash-table storage engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package hash_table_pkg;

    localparam int KEY_W = 4;
    localparam int VAL_W = 4;
    localparam int IDX_W = 3;

    // Command codes carried on cmd
    localparam logic [1:0] CMD_LOOKUP = 2'd0;
    localparam logic [1:0] CMD_INSERT = 2'd1;
    localparam logic [1:0] CMD_DELETE = 2'd2;
    localparam logic [1:0] CMD_CLEAR  = 2'd3;

    // Result codes carried on status
    localparam logic [1:0] ST_OK        = 2'd0;
    localparam logic [1:0] ST_NOT_FOUND = 2'd1;
    localparam logic [1:0] ST_FULL      = 2'd2;
    localparam logic [1:0] ST_BUSY      = 2'd3;

    // Per-slot occupancy. A tombstone keeps probe chains intact after a
    // delete while still being reusable by a later insert.
    typedef enum logic [1:0] {
        SLOT_EMPTY = 2'd0,
        SLOT_USED  = 2'd1,
        SLOT_TOMB  = 2'd2
    } slot_state_t;

endpackage : hash_table_pkg
`default_nettype wire

// File: rtl/probing_mem_slots.sv
`default_nettype none
// ============================================================================
//  Module      : probing_mem_slots
//  Description : Slot register array for the probing table. One asynchronous
//                combinational read port, one synchronous write port and a
//                synchronous global clear that empties every slot at once.
//  Ports       : clk, rst        - clock, async active-high reset (all EMPTY)
//                i_clear         - mark every slot EMPTY on this edge
//                i_ridx          - read index; o_rstate/o_rkey/o_rval
//                i_we, i_widx    - write enable and index
//                i_wstate/i_wkey/i_wval - data written to slot i_widx
//  Revision    : 1.0 - initial release
// ============================================================================
module probing_mem_slots
    import hash_table_pkg::*;
#(
    parameter int KEY_W = hash_table_pkg::KEY_W,
    parameter int VAL_W = hash_table_pkg::VAL_W,
    parameter int IDX_W = hash_table_pkg::IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic [IDX_W-1:0]  i_ridx,
    output slot_state_t       o_rstate,
    output logic [KEY_W-1:0]  o_rkey,
    output logic [VAL_W-1:0]  o_rval,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_widx,
    input  slot_state_t       i_wstate,
    input  logic [KEY_W-1:0]  i_wkey,
    input  logic [VAL_W-1:0]  i_wval
);

    localparam int c_depth = 2 ** IDX_W;

    slot_state_t      r_state [c_depth];
    logic [KEY_W-1:0] r_key   [c_depth];
    logic [VAL_W-1:0] r_val   [c_depth];

    // Clear only needs to touch the occupancy; stale key/value bits behind
    // an EMPTY slot are never observed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_depth; i++) begin
                r_state[i] <= SLOT_EMPTY;
                r_key[i]   <= '0;
                r_val[i]   <= '0;
            end
        end else if (i_clear) begin
            for (int i = 0; i < c_depth; i++) begin
                r_state[i] <= SLOT_EMPTY;
            end
        end else if (i_we) begin
            r_state[i_widx] <= i_wstate;
            r_key[i_widx]   <= i_wkey;
            r_val[i_widx]   <= i_wval;
        end
    end

    assign o_rstate = r_state[i_ridx];
    assign o_rkey   = r_key[i_ridx];
    assign o_rval   = r_val[i_ridx];

endmodule : probing_mem_slots
`default_nettype wire

// File: rtl/probing_mem_table.sv
`default_nettype none
// ============================================================================
//  Module      : probing_mem_table
//  Description : 8-entry key/value store with open addressing and linear
//                probing. Runs LOOKUP / INSERT / DELETE / CLEAR, examining one
//                slot per cycle starting at the supplied hash.
//  Ports       : clk, rst  - clock, async active-high reset (table cleared)
//                hash      - first slot to probe (sampled on accept)
//                key, val  - request key and insert value (sampled on accept)
//                cmd       - 0 LOOKUP, 1 INSERT, 2 DELETE, 3 CLEAR
//                go        - request strobe; one operation per high period
//                status    - 0 OK, 1 NOT_FOUND, 2 FULL, 3 BUSY
//                out       - result value
//  Revision    : 1.0 - initial release
// ============================================================================
module probing_mem_table
    import hash_table_pkg::*;
#(
    parameter int KEY_W = hash_table_pkg::KEY_W,
    parameter int VAL_W = hash_table_pkg::VAL_W,
    parameter int IDX_W = hash_table_pkg::IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  hash,
    input  logic [KEY_W-1:0]  key,
    input  logic [VAL_W-1:0]  val,
    input  logic [1:0]        cmd,
    input  logic              go,
    output logic [1:0]        status,
    output logic [VAL_W-1:0]  out
);

    // START is a single cycle that raises BUSY and loads the probe pointer,
    // so the k-th probe's result appears k edges after BUSY.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_PROBE = 2'd2
    } fsm_t;

    localparam logic [IDX_W-1:0] c_last_n = {IDX_W{1'b1}};

    fsm_t             r_state, w_state_nxt;
    logic             r_armed;
    logic [IDX_W-1:0] r_hash;
    logic [KEY_W-1:0] r_key;
    logic [VAL_W-1:0] r_val;
    logic [1:0]       r_cmd;
    logic [IDX_W-1:0] r_p, w_p_nxt;
    logic [IDX_W-1:0] r_n, w_n_nxt;
    logic             r_tomb_seen, w_tomb_seen_nxt;
    logic [IDX_W-1:0] r_tomb_idx, w_tomb_idx_nxt;
    logic [1:0]       r_status, w_status_nxt;
    logic [VAL_W-1:0] r_out, w_out_nxt;

    logic             w_accept;
    logic             w_clear;
    logic             w_we;
    logic [IDX_W-1:0] w_widx;
    slot_state_t      w_wstate;
    logic [KEY_W-1:0] w_wkey;
    logic [VAL_W-1:0] w_wval;

    slot_state_t      w_rstate;
    logic [KEY_W-1:0] w_rkey;
    logic [VAL_W-1:0] w_rval;

    logic             w_hit;
    logic             w_empty;
    logic             w_is_tomb;
    logic             w_last;
    logic [IDX_W-1:0] w_ins_idx;

    probing_mem_slots #(
        .KEY_W (KEY_W),
        .VAL_W (VAL_W),
        .IDX_W (IDX_W)
    ) u_slots (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_clear),
        .i_ridx   (r_p),
        .o_rstate (w_rstate),
        .o_rkey   (w_rkey),
        .o_rval   (w_rval),
        .i_we     (w_we),
        .i_widx   (w_widx),
        .i_wstate (w_wstate),
        .i_wkey   (w_wkey),
        .i_wval   (w_wval)
    );

    assign w_accept  = (r_state == S_IDLE) && go && r_armed;
    assign w_hit     = (w_rstate == SLOT_USED) && (w_rkey == r_key);
    assign w_empty   = (w_rstate == SLOT_EMPTY);
    assign w_is_tomb = (w_rstate == SLOT_TOMB);
    // r_n counts slots already examined; the current one is the last when
    // every other slot has been seen.
    assign w_last    = (r_n == c_last_n);
    // Inserts prefer the earliest tombstone on the chain over later slots.
    assign w_ins_idx = r_tomb_seen ? r_tomb_idx : r_p;

    always_comb begin
        w_state_nxt     = r_state;
        w_status_nxt    = r_status;
        w_out_nxt       = r_out;
        w_p_nxt         = r_p;
        w_n_nxt         = r_n;
        w_tomb_seen_nxt = r_tomb_seen;
        w_tomb_idx_nxt  = r_tomb_idx;
        w_clear         = 1'b0;
        w_we            = 1'b0;
        w_widx          = r_p;
        w_wstate        = SLOT_USED;
        w_wkey          = r_key;
        w_wval          = r_val;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_START;
                end
            end

            S_START: begin
                w_status_nxt    = ST_BUSY;
                w_p_nxt         = r_hash;
                w_n_nxt         = '0;
                w_tomb_seen_nxt = 1'b0;
                w_state_nxt     = S_PROBE;
            end

            S_PROBE: begin
                w_p_nxt = r_p + 1'b1;
                w_n_nxt = r_n + 1'b1;
                case (r_cmd)
                    CMD_LOOKUP: begin
                        if (w_hit) begin
                            w_status_nxt = ST_OK;
                            w_out_nxt    = w_rval;
                            w_state_nxt  = S_IDLE;
                        end else if (w_empty || w_last) begin
                            w_status_nxt = ST_NOT_FOUND;
                            w_out_nxt    = '0;
                            w_state_nxt  = S_IDLE;
                        end
                    end

                    CMD_INSERT: begin
                        if (w_hit) begin
                            w_we         = 1'b1;
                            w_status_nxt = ST_OK;
                            w_out_nxt    = r_val;
                            w_state_nxt  = S_IDLE;
                        end else if (w_empty) begin
                            w_we         = 1'b1;
                            w_widx       = w_ins_idx;
                            w_status_nxt = ST_OK;
                            w_out_nxt    = r_val;
                            w_state_nxt  = S_IDLE;
                        end else begin
                            if (w_is_tomb && !r_tomb_seen) begin
                                w_tomb_seen_nxt = 1'b1;
                                w_tomb_idx_nxt  = r_p;
                            end
                            if (w_last) begin
                                w_state_nxt = S_IDLE;
                                // The current slot may itself be the only
                                // tombstone on the whole chain.
                                if (r_tomb_seen || w_is_tomb) begin
                                    w_we         = 1'b1;
                                    w_widx       = w_ins_idx;
                                    w_status_nxt = ST_OK;
                                    w_out_nxt    = r_val;
                                end else begin
                                    w_status_nxt = ST_FULL;
                                    w_out_nxt    = '0;
                                end
                            end
                        end
                    end

                    CMD_DELETE: begin
                        if (w_hit) begin
                            w_we         = 1'b1;
                            w_wstate     = SLOT_TOMB;
                            w_wval       = w_rval;
                            w_status_nxt = ST_OK;
                            w_out_nxt    = w_rval;
                            w_state_nxt  = S_IDLE;
                        end else if (w_empty || w_last) begin
                            w_status_nxt = ST_NOT_FOUND;
                            w_out_nxt    = '0;
                            w_state_nxt  = S_IDLE;
                        end
                    end

                    default: begin
                        w_clear      = 1'b1;
                        w_status_nxt = ST_OK;
                        w_out_nxt    = '0;
                        w_state_nxt  = S_IDLE;
                    end
                endcase
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_armed     <= 1'b1;
            r_hash      <= '0;
            r_key       <= '0;
            r_val       <= '0;
            r_cmd       <= CMD_LOOKUP;
            r_p         <= '0;
            r_n         <= '0;
            r_tomb_seen <= 1'b0;
            r_tomb_idx  <= '0;
            r_status    <= ST_OK;
            r_out       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_p         <= w_p_nxt;
            r_n         <= w_n_nxt;
            r_tomb_seen <= w_tomb_seen_nxt;
            r_tomb_idx  <= w_tomb_idx_nxt;
            r_status    <= w_status_nxt;
            r_out       <= w_out_nxt;
            // Re-arm whenever go is low so a held strobe runs only once.
            r_armed     <= ~go | (r_armed & ~w_accept);
            if (w_accept) begin
                r_hash <= hash;
                r_key  <= key;
                r_val  <= val;
                r_cmd  <= cmd;
            end
        end
    end

    assign status = r_status;
    assign out    = r_out;

endmodule : probing_mem_table
`default_nettype wire

// File: tb/tb_probing_mem_table.sv
`default_nettype none
// ============================================================================
//  Module      : tb_probing_mem_table
//  Description : Self-checking bench for probing_mem_table: directed vector
//                table, hand-written corner sequences and random operations
//                checked against a slot-array reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_probing_mem_table;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] hash;
    logic [3:0] key;
    logic [3:0] val;
    logic [1:0] cmd;
    logic       go;
    logic [1:0] status;
    logic [3:0] out_v;

    int n_checks = 0;
    int n_fail   = 0;

    probing_mem_table dut (
        .clk    (clk),
        .rst    (rst),
        .hash   (hash),
        .key    (key),
        .val    (val),
        .cmd    (cmd),
        .go     (go),
        .status (status),
        .out    (out_v)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // slot state: 0 empty, 1 used, 2 tombstone
    int         m_st  [8];
    logic [3:0] m_key [8];
    logic [3:0] m_val [8];

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_st[i] = 0; m_key[i] = '0; m_val[i] = '0;
        end
    endtask

    task automatic model_op(input logic [1:0] c, input logic [2:0] h,
                            input logic [3:0] k, input logic [3:0] v,
                            output logic [1:0] st, output logic [3:0] o,
                            output int pr);
        int  ft;
        int  idx;
        int  tgt;
        bit  done;
        st = 2'd1; o = '0; pr = 8; ft = -1; done = 1'b0;
        if (c == 2'd3) begin
            for (int i = 0; i < 8; i++) m_st[i] = 0;
            st = 2'd0; pr = 1; done = 1'b1;
        end
        for (int i = 0; i < 8 && !done; i++) begin
            idx = (int'(h) + i) % 8;
            pr  = i + 1;
            if (m_st[idx] == 1 && m_key[idx] == k) begin
                done = 1'b1; st = 2'd0;
                if (c == 2'd0) o = m_val[idx];
                else if (c == 2'd1) begin m_val[idx] = v; o = v; end
                else begin o = m_val[idx]; m_st[idx] = 2; end
            end else if (m_st[idx] == 0) begin
                done = 1'b1;
                if (c == 2'd1) begin
                    tgt = (ft >= 0) ? ft : idx;
                    m_st[tgt] = 1; m_key[tgt] = k; m_val[tgt] = v;
                    st = 2'd0; o = v;
                end
            end else if (m_st[idx] == 2 && ft < 0) begin
                ft = idx;
            end
        end
        if (!done && c == 2'd1) begin
            if (ft >= 0) begin
                m_st[ft] = 1; m_key[ft] = k; m_val[ft] = v;
                st = 2'd0; o = v;
            end else begin
                st = 2'd2; o = '0;
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one single-cycle go and check BUSY, latency and result.
    task automatic do_op(input logic [1:0] c, input logic [2:0] h,
                         input logic [3:0] k, input logic [3:0] v,
                         input logic [1:0] es, input logic [3:0] eo,
                         input int ek, input string tag);
        int cyc;
        @(posedge clk); #1;
        cmd = c; hash = h; key = k; val = v; go = 1'b1;
        @(posedge clk); #1;            // edge A samples go
        go = 1'b0;
        @(posedge clk); #1;            // edge A+1
        check({tag, " busy"}, status, 3);
        cyc = 0;
        while (status == 2'd3 && cyc < 12) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " latency"}, cyc, ek);
        check({tag, " status"}, status, es);
        check({tag, " out"}, out_v, eo);
    endtask

    task automatic run_model(input logic [1:0] c, input logic [2:0] h,
                             input logic [3:0] k, input logic [3:0] v, input string tag);
        logic [1:0] st;
        logic [3:0] o;
        int         pr;
        model_op(c, h, k, v, st, o, pr);
        do_op(c, h, k, v, st, o, pr, tag);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct packed {
        logic [1:0] c;
        logic [2:0] h;
        logic [3:0] k;
        logic [3:0] v;
        logic [1:0] es;
        logic [3:0] eo;
        logic [3:0] ek;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] c, input logic [2:0] h, input logic [3:0] k,
                                input logic [3:0] v, input logic [1:0] es, input logic [3:0] eo,
                                input logic [3:0] ek);
        vec_t r;
        r.c = c; r.h = h; r.k = k; r.v = v; r.es = es; r.eo = eo; r.ek = ek;
        return r;
    endfunction

    vec_t vecs [28];

    initial begin
        logic [1:0] st;
        logic [3:0] o;
        int         pr;
        int         busy_cnt;
        logic [1:0] prev;

        //            cmd   h     k      v      st    out    k
        vecs[0]  = mk(2'd0, 3'd2, 4'd5,  4'd0,  2'd1, 4'd0,  4'd1);
        vecs[1]  = mk(2'd1, 3'd2, 4'd5,  4'd9,  2'd0, 4'd9,  4'd1);
        vecs[2]  = mk(2'd0, 3'd2, 4'd5,  4'd0,  2'd0, 4'd9,  4'd1);
        vecs[3]  = mk(2'd1, 3'd2, 4'd5,  4'd3,  2'd0, 4'd3,  4'd1);
        vecs[4]  = mk(2'd0, 3'd2, 4'd5,  4'd0,  2'd0, 4'd3,  4'd1);
        vecs[5]  = mk(2'd1, 3'd7, 4'd1,  4'd1,  2'd0, 4'd1,  4'd1);
        vecs[6]  = mk(2'd1, 3'd7, 4'd2,  4'd2,  2'd0, 4'd2,  4'd2);
        vecs[7]  = mk(2'd1, 3'd7, 4'd3,  4'd4,  2'd0, 4'd4,  4'd3);
        vecs[8]  = mk(2'd0, 3'd7, 4'd3,  4'd0,  2'd0, 4'd4,  4'd3);
        vecs[9]  = mk(2'd2, 3'd7, 4'd2,  4'd0,  2'd0, 4'd2,  4'd2);
        vecs[10] = mk(2'd0, 3'd7, 4'd3,  4'd0,  2'd0, 4'd4,  4'd3);
        vecs[11] = mk(2'd0, 3'd7, 4'd2,  4'd0,  2'd1, 4'd0,  4'd5);
        vecs[12] = mk(2'd1, 3'd7, 4'd4,  4'd6,  2'd0, 4'd6,  4'd5);
        vecs[13] = mk(2'd0, 3'd0, 4'd4,  4'd0,  2'd0, 4'd6,  4'd1);
        vecs[14] = mk(2'd1, 3'd3, 4'd6,  4'd7,  2'd0, 4'd7,  4'd1);
        vecs[15] = mk(2'd1, 3'd4, 4'd7,  4'd8,  2'd0, 4'd8,  4'd1);
        vecs[16] = mk(2'd1, 3'd5, 4'd8,  4'd10, 2'd0, 4'd10, 4'd1);
        vecs[17] = mk(2'd1, 3'd6, 4'd9,  4'd11, 2'd0, 4'd11, 4'd1);
        vecs[18] = mk(2'd1, 3'd0, 4'd10, 4'd12, 2'd2, 4'd0,  4'd8);
        vecs[19] = mk(2'd0, 3'd3, 4'd10, 4'd0,  2'd1, 4'd0,  4'd8);
        vecs[20] = mk(2'd0, 3'd0, 4'd9,  4'd0,  2'd0, 4'd11, 4'd7);
        vecs[21] = mk(2'd2, 3'd1, 4'd11, 4'd0,  2'd1, 4'd0,  4'd8);
        vecs[22] = mk(2'd1, 3'd4, 4'd5,  4'd13, 2'd0, 4'd13, 4'd7);
        vecs[23] = mk(2'd2, 3'd7, 4'd1,  4'd0,  2'd0, 4'd1,  4'd1);
        vecs[24] = mk(2'd1, 3'd0, 4'd12, 4'd14, 2'd0, 4'd14, 4'd8);
        vecs[25] = mk(2'd0, 3'd7, 4'd12, 4'd0,  2'd0, 4'd14, 4'd1);
        vecs[26] = mk(2'd3, 3'd0, 4'd0,  4'd0,  2'd0, 4'd0,  4'd1);
        vecs[27] = mk(2'd0, 3'd1, 4'd3,  4'd0,  2'd1, 4'd0,  4'd1);

        rst = 1'b1; go = 1'b0; cmd = '0; hash = '0; key = '0; val = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset status", status, 0);
        check("reset out", out_v, 0);
        rst = 1'b0;

        // Directed table; the model tracks along so later phases stay in sync.
        for (int i = 0; i < 28; i++) begin
            model_op(vecs[i].c, vecs[i].h, vecs[i].k, vecs[i].v, st, o, pr);
            do_op(vecs[i].c, vecs[i].h, vecs[i].k, vecs[i].v,
                  vecs[i].es, vecs[i].eo, int'(vecs[i].ek), $sformatf("vec%0d", i));
        end

        // Held go: a DELETE held for 20 cycles must run exactly once.
        run_model(2'd1, 3'd0, 4'd1, 4'd5, "hold setup");
        model_op(2'd2, 3'd0, 4'd1, 4'd0, st, o, pr);
        @(posedge clk); #1;
        cmd = 2'd2; hash = 3'd0; key = 4'd1; go = 1'b1;
        prev = status; busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (status == 2'd3 && prev != 2'd3) busy_cnt++;
            prev = status;
        end
        go = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("hold ops", busy_cnt, 1);
        check("hold status", status, st);
        check("hold out", out_v, o);
        run_model(2'd0, 3'd0, 4'd1, 4'd0, "hold after");
        run_model(2'd1, 3'd0, 4'd2, 4'd3, "tomb reuse");

        // Reset in the middle of an operation.
        @(posedge clk); #1;
        cmd = 2'd0; hash = 3'd0; key = 4'd9; go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        @(posedge clk); #3;
        check("midrst busy", status, 3);
        rst = 1'b1;
        #1;
        check("midrst status", status, 0);
        check("midrst out", out_v, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        run_model(2'd0, 3'd0, 4'd2, 4'd0, "after rst");

        // Random operations against the model.
        for (int i = 0; i < 80; i++) begin
            int         r;
            logic [1:0] c;
            r = int'($urandom_range(0, 15));
            if (r == 0)       c = 2'd3;
            else if (r < 6)   c = 2'd0;
            else if (r < 12)  c = 2'd1;
            else              c = 2'd2;
            run_model(c, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 5)),
                      4'($urandom_range(0, 15)), $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule : tb_probing_mem_table
`default_nettype wire
